// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling 8N1 UART receiver behind a 2-FF input synchroniser.
// Each good frame updates data_o with a one-cycle data_v_o strobe; a low stop bit pulses frame_err_o.
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT    = 16,
   parameter int UART_DATA_WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       rx_i,
   output logic [UART_DATA_WIDTH-1:0] data_o,
   output logic                       data_v_o,
   output logic                       frame_err_o,
   output logic                       busy_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (UART_DATA_WIDTH > 1) ? $clog2(UART_DATA_WIDTH) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_BREAK,
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e                     state_q, state_d;
   logic [CW-1:0]              bit_ctr_q, bit_ctr_d;
   logic [IW-1:0]              bit_idx_q, bit_idx_d;
   logic [UART_DATA_WIDTH-1:0] sh_q, sh_d;
   logic [UART_DATA_WIDTH-1:0] data_d;
   logic                       data_v_d, frame_err_d;
   logic                       rx_meta, rx_s;

   // NOTE: the synchroniser resets to the idle level so reset release never mimics a start bit.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      bit_ctr_d   = bit_ctr_q;
      bit_idx_d   = bit_idx_q;
      sh_d        = sh_q;
      data_d      = data_o;
      data_v_d    = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (!rx_s) begin
               state_d   = S_START;
               bit_ctr_d = '0;
            end
         end
         S_START: begin
            if (bit_ctr_q == HALF_LAST) begin
               bit_ctr_d = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? S_IDLE : S_DATA;
            end else begin
               bit_ctr_d = bit_ctr_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_ctr_q == BIT_LAST) begin
               bit_ctr_d = '0;
               sh_d      = {rx_s, sh_q[UART_DATA_WIDTH-1:1]};
               if (bit_idx_q == IDX_LAST) state_d = S_STOP;
               else                       bit_idx_d = bit_idx_q + 1'b1;
            end else begin
               bit_ctr_d = bit_ctr_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_ctr_q == BIT_LAST) begin
               bit_ctr_d = '0;
               if (rx_s) begin
                  data_d   = sh_q;
                  data_v_d = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               bit_ctr_d = bit_ctr_q + 1'b1;
            end
         end
         default: state_d = S_BREAK;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_BREAK;
         bit_ctr_q   <= '0;
         bit_idx_q   <= '0;
         sh_q        <= '0;
         data_o      <= '0;
         data_v_o    <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_ctr_q   <= bit_ctr_d;
         bit_idx_q   <= bit_idx_d;
         sh_q        <= sh_d;
         data_o      <= data_d;
         data_v_o    <= data_v_d;
         frame_err_o <= frame_err_d;
      end
   end

   assign busy_o = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed and random frames against a frame-level timing model,
// plus a second instance with 4 clocks per bit driven at a skewed baud rate.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   localparam int W    = 8;
   // Edge at which a consumer captures the strobe, counted from e0 (first edge seeing rx_i low).
   localparam int LAT  = 2 + HALF + (W + 1) * CPB + 1;

   typedef struct {
      int           at;
      logic         err;
      logic [W-1:0] data;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         rx16 = 1'b1;
   logic         rx4 = 1'b1;
   logic [W-1:0] data16, data4;
   logic         dv16, fe16, busy16;
   logic         dv4, fe4, busy4;

   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   int           fe4_cnt = 0;
   ev_t          obs_q[$];
   ev_t          exp_q[$];
   logic [W-1:0] got4_q[$];
   logic [W-1:0] exp4_q[$];
   logic         armed = 1'b0;
   logic [W-1:0] last_good = '0;

   uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .UART_DATA_WIDTH(W)) dut16 (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .rx_i       (rx16),
      .data_o     (data16),
      .data_v_o   (dv16),
      .frame_err_o(fe16),
      .busy_o     (busy16)
   );

   uart_rx_ctrl #(.CLKS_PER_BIT(4), .UART_DATA_WIDTH(W)) dut4 (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .rx_i       (rx4),
      .data_o     (data4),
      .data_v_o   (dv4),
      .frame_err_o(fe4),
      .busy_o     (busy4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dv16 || fe16) obs_q.push_back('{cyc + 1, fe16, data16});
      if (dv4) got4_q.push_back(data4);
      if (fe4) fe4_cnt <= fe4_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Line held high long enough for the receiver to see idle re-arms it after a framing error.
   task automatic idle16(input int n);
      rx16 = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      if (n >= 4) armed = 1'b1;
   endtask

   // Called #1 after a posedge; the start bit is captured at the next edge (e0).
   task automatic send16(input logic [W-1:0] b, input logic stop_bit);
      logic [W+1:0] bits;
      bits = {stop_bit, b, 1'b0};
      if (armed) begin
         if (stop_bit) begin
            exp_q.push_back('{cyc + 1 + LAT, 1'b0, b});
            last_good = b;
         end else begin
            exp_q.push_back('{cyc + 1 + LAT, 1'b1, last_good});
            armed = 1'b0;
         end
      end
      for (int j = 0; j < W + 2; j++) begin
         rx16 = bits[j];
         repeat (CPB) @(posedge clk);
         #1;
      end
   endtask

   task automatic check_log(input string tag);
      ev_t o, e;
      check({tag, ":count"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check({tag, ":at"},   o.at,   e.at);
         check({tag, ":kind"}, o.err,  e.err);
         check({tag, ":data"}, o.data, e.data);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   // Asynchronous frame on the 4-clock-per-bit instance with an arbitrary bit period in ns.
   task automatic send4(input logic [W-1:0] b, input real bit_ns);
      @(posedge clk);
      #9;
      exp4_q.push_back(b);
      rx4 = 1'b0;
      #(bit_ns);
      for (int k = 0; k < W; k++) begin
         rx4 = b[k];
         #(bit_ns);
      end
      rx4 = 1'b1;
      #(bit_ns);
      repeat (10) @(posedge clk);
   endtask

   initial begin
      int           e0;
      logic [W+1:0] partial;
      logic [W-1:0] rb;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst:data",  data16, 0);
      check("rst:dv",    dv16,   0);
      check("rst:fe",    fe16,   0);
      check("rst:busy",  busy16, 0);
      @(negedge clk) rst_n = 1'b1;
      armed = 1'b1;
      @(posedge clk);
      #1;
      idle16(8);

      // Single ideal frame
      send16(8'hA5, 1'b1);
      idle16(20);
      check_log("single");
      check("single:data_o", data16, 8'hA5);

      // Back-to-back frames with no idle time
      send16(8'h00, 1'b1);
      send16(8'hFF, 1'b1);
      send16(8'h3C, 1'b1);
      idle16(20);
      check_log("b2b");

      // Start-bit glitch: low for 3 cycles only
      e0 = cyc + 1;
      rx16 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx16 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("glitch:busy", busy16, (cyc >= e0 + 2) && (cyc < e0 + 2 + HALF));
      end
      @(posedge clk);
      #1;
      idle16(4);
      send16(8'h5A, 1'b1);
      idle16(20);
      check_log("glitch");

      // Framing error, then line held low for 50 bits
      send16(8'h81, 1'b0);
      repeat (50 * CPB) @(posedge clk);
      #1;
      check_log("ferr");
      check("ferr:data_kept", data16, 8'h5A);
      idle16(20);
      send16(8'h42, 1'b1);
      idle16(20);
      check_log("after_break");

      // Reset in the middle of the data bits of 0x77
      partial = {1'b1, 8'h77, 1'b0};
      for (int j = 0; j < 5; j++) begin
         rx16 = partial[j];
         repeat (CPB) @(posedge clk);
         #1;
      end
      check("midrst:busy_before", busy16, 1);
      rst_n = 1'b0;
      #1;
      check("midrst:data", data16, 0);
      check("midrst:dv",   dv16,   0);
      check("midrst:fe",   fe16,   0);
      check("midrst:busy", busy16, 0);
      rx16 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      obs_q.delete();
      idle16(8);
      send16(8'h99, 1'b1);
      idle16(20);
      check_log("post_reset");

      // Random bytes with random idle gaps (0 = back-to-back)
      for (int n = 0; n < 8; n++) begin
         rb = W'($urandom);
         idle16(int'($urandom_range(0, 3)));
         send16(rb, 1'b1);
      end
      idle16(20);
      check_log("random");

      // 4 clocks per bit, baud skewed by +3% and -3%
      send4(8'h55, 41.2);
      send4(8'hAA, 38.8);
      send4(8'h55, 38.8);
      send4(8'hAA, 41.2);
      check("skew:count", got4_q.size(), exp4_q.size());
      while (got4_q.size() > 0 && exp4_q.size() > 0)
         check("skew:data", got4_q.pop_front(), exp4_q.pop_front());
      check("skew:ferr", fe4_cnt, 0);
      check("skew:busy", busy4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
